// File: rtl/uart_frame_rx_param.sv
// uart_frame_rx_param
// Frame receiver that sits behind a byte-level UART RX core. It parses
// HEAD0 HEAD1 ADDR LEN DATA[0..LEN-1] CRC TAIL, checks a CRC-8 over ADDR/LEN/DATA,
// and publishes a double-buffered payload that only changes on a committed frame.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   uart_rx_done          one-cycle strobe, uart_rx_data_o holds a valid byte
//   uart_rx_data_o        received byte
//   rx_frame_vld          pulse, new payload committed (TAIL_CMD)
//   start                 pulse, frame accepted with TAIL_CMD or TAIL_START
//   frame_addr/len/data   last committed frame; payload byte i at [8*i+7:8*i]
//   crc_err/len_err/tail_err/timeout_err   one-cycle error pulses
//   good_cnt, err_cnt     saturating statistics counters
module uart_frame_rx_param #(
    parameter int          MAX_LEN     = 26,
    parameter logic [7:0]  HEAD0       = 8'h55,
    parameter logic [7:0]  HEAD1       = 8'hAA,
    parameter logic [7:0]  TAIL_CMD    = 8'hF0,
    parameter logic [7:0]  TAIL_START  = 8'h01,
    parameter logic [7:0]  CRC_POLY    = 8'h07,
    parameter int          TIMEOUT_CYC = 100000,
    parameter int          CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   uart_rx_done,
    input  logic [7:0]             uart_rx_data_o,
    output logic                   rx_frame_vld,
    output logic                   start,
    output logic [7:0]             frame_addr,
    output logic [7:0]             frame_len,
    output logic [8*MAX_LEN-1:0]   frame_data,
    output logic                   crc_err,
    output logic                   len_err,
    output logic                   tail_err,
    output logic                   timeout_err,
    output logic [CNT_W-1:0]       good_cnt,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam int         TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE, ST_H1, ST_ADDR, ST_LEN, ST_DATA, ST_CRC, ST_TAIL
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [7:0]             addr_w_r;
    logic [7:0]             len_w_r;
    logic [7:0]             cnt_r;
    logic [7:0]             crc_r;
    logic [7:0]             buf_r [MAX_LEN];
    logic [TO_W-1:0]        idle_cnt_r;

    logic                   timeout_hit_s;
    logic                   take_s;
    logic                   crc_err_s, len_err_s, tail_err_s, to_err_s;
    logic                   commit_s, start_s, any_err_s;
    logic [7:0]             crc_fold_s;

    // CRC-8, MSB first, one byte folded per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data_in);
        logic [7:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = (c << 1) ^ CRC_POLY;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

    // A timeout wins over a byte arriving in the same cycle.
    assign timeout_hit_s = (TIMEOUT_CYC != 0) && (state_r != ST_IDLE) && (idle_cnt_r == TO_LAST);
    assign take_s        = uart_rx_done && !timeout_hit_s;
    assign crc_fold_s    = crc8_step(crc_r, uart_rx_data_o);
    assign any_err_s     = crc_err_s | len_err_s | tail_err_s | to_err_s;

    // Next-state and pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        crc_err_s   = 1'b0;
        len_err_s   = 1'b0;
        tail_err_s  = 1'b0;
        to_err_s    = 1'b0;
        commit_s    = 1'b0;
        start_s     = 1'b0;
        if (timeout_hit_s) begin
            state_nxt_s = ST_IDLE;
            to_err_s    = 1'b1;
        end else if (uart_rx_done) begin
            case (state_r)
                ST_IDLE: begin
                    if (uart_rx_data_o == HEAD0) state_nxt_s = ST_H1;
                    else                         state_nxt_s = ST_IDLE;
                end
                ST_H1: begin
                    if (uart_rx_data_o == HEAD1)      state_nxt_s = ST_ADDR;
                    else if (uart_rx_data_o == HEAD0) state_nxt_s = ST_H1;
                    else                              state_nxt_s = ST_IDLE;
                end
                ST_ADDR: state_nxt_s = ST_LEN;
                ST_LEN: begin
                    if (uart_rx_data_o > MAX_LEN_B) begin
                        len_err_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (uart_rx_data_o == 8'd0) begin
                        state_nxt_s = ST_CRC;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == len_w_r - 8'd1) state_nxt_s = ST_CRC;
                    else                         state_nxt_s = ST_DATA;
                end
                ST_CRC: begin
                    if (uart_rx_data_o == crc_r) begin
                        state_nxt_s = ST_TAIL;
                    end else begin
                        crc_err_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_TAIL: begin
                    state_nxt_s = ST_IDLE;
                    if (uart_rx_data_o == TAIL_CMD) begin
                        commit_s = 1'b1;
                        start_s  = 1'b1;
                    end else if (uart_rx_data_o == TAIL_START) begin
                        start_s  = 1'b1;
                    end else begin
                        tail_err_s = 1'b1;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Inter-byte idle counter; only runs while a frame is in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_r <= '0;
        end else if (state_r == ST_IDLE || uart_rx_done || timeout_hit_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + TO_W'(1);
        end
    end

    // Working buffer, address/length latches and running CRC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_w_r <= 8'd0;
            len_w_r  <= 8'd0;
            cnt_r    <= 8'd0;
            crc_r    <= 8'd0;
            for (int i = 0; i < MAX_LEN; i++) buf_r[i] <= 8'd0;
        end else if (take_s) begin
            case (state_r)
                ST_ADDR: begin
                    addr_w_r <= uart_rx_data_o;
                    crc_r    <= crc8_step(8'd0, uart_rx_data_o);
                end
                ST_LEN: begin
                    len_w_r <= uart_rx_data_o;
                    crc_r   <= crc_fold_s;
                    cnt_r   <= 8'd0;
                    for (int i = 0; i < MAX_LEN; i++) buf_r[i] <= 8'd0;
                end
                ST_DATA: begin
                    if (cnt_r < MAX_LEN_B) buf_r[cnt_r] <= uart_rx_data_o;
                    crc_r <= crc_fold_s;
                    cnt_r <= cnt_r + 8'd1;
                end
                default: crc_r <= crc_r;
            endcase
        end
    end

    // Registered pulses, committed outputs and saturating statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_frame_vld <= 1'b0;
            start        <= 1'b0;
            crc_err      <= 1'b0;
            len_err      <= 1'b0;
            tail_err     <= 1'b0;
            timeout_err  <= 1'b0;
            frame_addr   <= 8'd0;
            frame_len    <= 8'd0;
            frame_data   <= '0;
            good_cnt     <= '0;
            err_cnt      <= '0;
        end else begin
            rx_frame_vld <= commit_s;
            start        <= start_s;
            crc_err      <= crc_err_s;
            len_err      <= len_err_s;
            tail_err     <= tail_err_s;
            timeout_err  <= to_err_s;
            if (commit_s) begin
                frame_addr <= addr_w_r;
                frame_len  <= len_w_r;
                for (int i = 0; i < MAX_LEN; i++) frame_data[8*i +: 8] <= buf_r[i];
            end
            if (start_s && (good_cnt != {CNT_W{1'b1}})) good_cnt <= good_cnt + CNT_W'(1);
            if (any_err_s && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/uart_frame_rx_param.md
Name: uart_frame_rx_param

Overview:
- Parametrised next-generation UART frame receiver. Sits between the byte-level UART RX core and the command and register logic.
- Parses frames of the form HEAD0 HEAD1 ADDR LEN DATA[0..LEN-1] CRC TAIL.
- Computes CRC-8 internally, so no external CRC module is needed.
- Publishes a double-buffered payload and reports errors. Adds length checking, an inter-byte timeout, head resync and frame statistics.

Parameters:
- MAX_LEN, 26, maximum payload bytes; sizes the payload bus.
- HEAD0, 8'h55, first head byte.
- HEAD1, 8'hAA, second head byte.
- TAIL_CMD, 8'hF0, tail byte that commits the payload and pulses start.
- TAIL_START, 8'h01, tail byte that pulses start only; payload is not committed.
- CRC_POLY, 8'h07, CRC-8 polynomial. MSB-first, init 8'h00, no reflection, no final XOR.
- TIMEOUT_CYC, 100000, idle clock cycles allowed between bytes inside a frame; 0 disables the timeout.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- uart_rx_done  in  1  one-cycle strobe; a byte is valid.
- uart_rx_data_o  in  8  received byte.
- rx_frame_vld  out  1  one-cycle pulse; a new payload is committed.
- start  out  1  one-cycle pulse on an accepted TAIL_CMD or TAIL_START.
- frame_addr  out  8  address of the last committed frame.
- frame_len  out  8  LEN of the last committed frame.
- frame_data  out  8*MAX_LEN  committed payload; byte i at [8*i+7:8*i].
- crc_err  out  1  pulse; CRC mismatch.
- len_err  out  1  pulse; LEN > MAX_LEN.
- tail_err  out  1  pulse; unknown tail byte.
- timeout_err  out  1  pulse; inter-byte timeout.
- good_cnt  out  CNT_W  count of accepted frames (either tail).
- err_cnt  out  CNT_W  count of error pulses, all error types combined.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All outputs, counters, the working buffer and the CRC register clear to 0.
- The FSM advances only on uart_rx_done, except for the timeout path. States and transitions:
  - IDLE: byte == HEAD0 -> H1.
  - H1: byte == HEAD1 -> ADDR. Byte == HEAD0 -> stay in H1 (resync). Any other byte -> IDLE.
  - ADDR: latch the working address, crc <= f(0, byte) -> LEN.
  - LEN:
    - byte > MAX_LEN -> len_err, IDLE.
    - byte == 0 -> CRC.
    - otherwise -> DATA.
    - In every case the byte is folded into crc and latched as the working length; the working buffer is cleared to 0.
  - DATA: write byte at index cnt, fold into crc, cnt++. When cnt == LEN-1 on the write -> CRC.
  - CRC:
    - byte == crc -> TAIL.
    - else crc_err, IDLE.
  - TAIL:
    - TAIL_CMD -> commit working addr/len/buffer to outputs, rx_frame_vld=1 and start=1 for one cycle, good_cnt++, IDLE.
    - TAIL_START -> start=1 only, good_cnt++, IDLE.
    - Other -> tail_err, IDLE.
- Output timing: all pulses occur in the cycle after the accepting uart_rx_done (registered). Committed outputs change in the same cycle as rx_frame_vld.
- CRC covers ADDR, LEN and DATA only. The CRC is folded combinationally with one byte per strobe.
- Timeout: an idle counter runs in every state except IDLE. It resets on each uart_rx_done. When it reaches TIMEOUT_CYC: timeout_err pulse, IDLE, partial frame discarded.
- Committed outputs hold their values through errors and incomplete frames (double buffering).
- Counters saturate at all ones; they never wrap.
- err_cnt increments by 1 per error pulse. At most one error can occur per cycle.
- A uart_rx_done arriving in the same cycle the timeout fires: the timeout wins and the byte is dropped.
- Reset asserted mid-frame: the frame is lost immediately; committed outputs clear to 0.

Test Plan:
- Good frame 55 AA 01 01 02 70 F0 -> one rx_frame_vld and start pulse; frame_addr=01, frame_len=01, frame_data[7:0]=02, all other payload bytes 0; good_cnt=1.
- Same frame with CRC byte 71 -> crc_err pulse, no rx_frame_vld, payload unchanged, err_cnt=1; a following good frame is accepted.
- 55 AA 01 1B ... (LEN=27 > 26) -> len_err right after the LEN byte; subsequent bytes are ignored until the next 55 AA.
- 55 55 AA 01 01 02 70 01 -> resync accepted; start pulse only; rx_frame_vld stays 0; payload unchanged; good_cnt++.
- With TIMEOUT_CYC=50: 55 AA 01, then silence -> timeout_err exactly 50 cycles after the last strobe; state returns to IDLE.
- Full 26-byte frame, then 0-length frame 55 AA 02 00 CRC F0 -> second commit: frame_len=0, all payload bytes 0; reset_n pulsed low mid-frame -> all outputs 0 asynchronously.
